snax_memset_stream: RTL
=======================

// Module: snax_memset_stream
// PURPOSE
//  Streaming fill/pattern generator for the SNAX accelerator data path, between the streamer read and
//  write ports. Per job (CSR-configured, kicked by ext_start_i) it consumes exactly N input beats and
//  emits N output beats: constant fill, arithmetic ramp, or pass-through. One registered output stage.
// PARAMETERS
//  DataWidth    512  stream beat width (bits); DataWidth % PatternWidth == 0
//  PatternWidth 32   lane width (bits); one of 8/16/32. Lanes = DataWidth/PatternWidth
//  UserCsrNum   3    number of 32-bit user CSRs (fixed at 3)
// PORTS
//  clk               in   1          clock; all logic on rising edge
//  rst_n             in   1          reset, synchronous, active-low
//  ext_data_i_valid  in   1          input beat valid
//  ext_data_i_ready  out  1          input beat accepted when valid&ready
//  ext_data_i_bits   in   DataWidth  input beat
//  ext_data_o_valid  out  1          output beat valid (registered)
//  ext_data_o_ready  in   1          downstream ready
//  ext_data_o_bits   out  DataWidth  output beat (registered)
//  ext_csr_i_0       in   32         pattern base, [PatternWidth-1:0] used
//  ext_csr_i_1       in   32         beat count N (unsigned)
//  ext_csr_i_2       in   32         [1:0] mode: 0 FILL, 1 RAMP, 2 BYPASS, 3 = FILL; [31:16] ramp step
//  ext_start_i       in   1          start pulse; sampled only in IDLE
//  ext_busy_o        out  1          high while job active
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, ext_busy_o=0, ext_data_o_valid=0, ext_data_o_bits=0,
//    counters=0, latched CSRs=0. Reset mid-job aborts it; held output beat is dropped.
//  - States IDLE, RUN. IDLE->RUN on ext_start_i=1 with csr_1!=0: latch pattern, N, mode, step;
//    in_left=N, out_left=N; ext_busy_o=1 from next cycle. start with N=0: ignored, stay IDLE.
//    ext_start_i in RUN ignored; CSR changes during RUN have no effect.
//  - RUN->IDLE on the cycle the output handshake with out_left==1 completes; ext_busy_o=0 next cycle.
//  - ext_data_i_ready = RUN && in_left!=0 && (!ext_data_o_valid || ext_data_o_ready). Combinational
//    ready; 0 in IDLE. Input beat consumed in all modes (1 in : 1 out).
//  - On input handshake: output register loads computed beat, ext_data_o_valid=1 next cycle
//    (latency 1); in_left decrements. Simultaneous out-handshake + in-handshake: reg reloads, valid
//    stays 1 (full throughput, 1 beat/cycle). Out-handshake without new input: valid->0.
//  - While valid && !ready: ext_data_o_bits/valid held stable.
//  - Lane k (bits [k*PW +: PW]) of output beat b:
//      FILL:   pattern
//      RAMP:   pattern + step*(b*Lanes + k), mod 2^PW (step zero-extended/truncated to PW)
//      BYPASS: ext_data_i_bits lane k
//    RAMP via running base_r: base_r=pattern at start; lane k=base_r+step*k; base_r += step*Lanes on
//    each input handshake. All arithmetic wraps silently at PW bits.
//  - Input valid while in_left==0 or IDLE: not accepted (ready=0), no side effects.
// TESTING
//  1 FILL: csr0=0xDEADBEEF, N=4, in valid always, out ready always -> 4 beats, every lane
//    0xDEADBEEF, back-to-back; busy high 5 cycles then 0; 5th input beat not accepted.
//  2 RAMP: csr0=0, step=1, N=2 -> beat0 lanes 0..15, beat1 lanes 16..31; step=3 base=0xFFFFFFFF
//    -> beat0 lane0=0xFFFFFFFF, lane1=0x00000002.
//  3 Backpressure: BYPASS N=3, out_ready low 3 cycles after first valid -> bits/valid stable,
//    in_ready=0 while held; all 3 beats exit in order, equal to inputs.
//  4 N=0 start -> busy stays 0, no beats; start pulse during RUN -> ignored, count unchanged.
//  5 Reset mid-job: rst_n=0 after 2 of 5 beats -> next cycle valid=0, busy=0, ready=0; new
//    job N=1 then runs correctly.
//  6 CSR change during RUN (csr0 0x11111111 -> 0x22222222) -> all beats of job keep 0x11111111.

Source files
------------

// File: rtl/snax_memset_stream.sv
`default_nettype none
// ============================================================================
//  Module   : snax_memset_stream
//  Brief    : Streaming fill / ramp / pass-through beat generator. Each job
//             consumes N input beats and emits N output beats through a
//             single registered output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module snax_memset_stream #(
    parameter int DataWidth    = 512,
    parameter int PatternWidth = 32,
    parameter int UserCsrNum   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ext_data_i_valid,
    output logic                 ext_data_i_ready,
    input  logic [DataWidth-1:0] ext_data_i_bits,
    output logic                 ext_data_o_valid,
    input  logic                 ext_data_o_ready,
    output logic [DataWidth-1:0] ext_data_o_bits,
    input  logic [31:0]          ext_csr_i_0,
    input  logic [31:0]          ext_csr_i_1,
    input  logic [31:0]          ext_csr_i_2,
    input  logic                 ext_start_i,
    output logic                 ext_busy_o
);

    localparam int c_lanes = DataWidth / PatternWidth;

    localparam logic [1:0] c_mode_ramp   = 2'd1;
    localparam logic [1:0] c_mode_bypass = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Elaboration-time guard on the parameter set
    generate
        if (((DataWidth % PatternWidth) != 0) || (UserCsrNum != 3)) begin : g_bad_params
            $error("snax_memset_stream: unsupported parameter combination");
        end
    endgenerate

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_valid;
    logic [DataWidth-1:0]    r_bits;
    logic [31:0]             r_in_left;
    logic [31:0]             r_out_left;
    logic [PatternWidth-1:0] r_pattern;
    logic [PatternWidth-1:0] r_step;
    logic [PatternWidth-1:0] r_base;
    logic [1:0]              r_mode;

    logic                     w_in_hs;
    logic                     w_out_hs;
    logic                     w_in_ready;
    logic [PatternWidth+15:0] w_step_ext;
    logic [PatternWidth-1:0]  w_step;
    logic [PatternWidth-1:0]  w_base_inc;
    logic [DataWidth-1:0]     w_fill;
    logic [DataWidth-1:0]     w_ramp;
    logic [DataWidth-1:0]     w_beat;
    logic                     w_unused;

    // Ramp step is a 16-bit CSR field, zero-extended or truncated to lane width
    assign w_step_ext = {{PatternWidth{1'b0}}, ext_csr_i_2[31:16]};
    assign w_step     = w_step_ext[PatternWidth-1:0];

    // CSR bits outside the used fields
    assign w_unused = ^{ext_csr_i_0, ext_csr_i_2[15:2], w_step_ext};

    // Accept input only while the job still needs beats and the output slot frees up
    assign w_in_ready = (r_state == RUN) && (r_in_left != 32'd0) &&
                        (!r_valid || ext_data_o_ready);
    assign w_in_hs    = ext_data_i_valid && w_in_ready;
    assign w_out_hs   = r_valid && ext_data_o_ready;

    // Running base advances by one full beat worth of lanes per accepted input
    assign w_base_inc = r_step * PatternWidth'(c_lanes);

    // Per-lane fill and ramp values; ramp lanes are base plus step times lane index
    generate
        for (genvar k = 0; k < c_lanes; k++) begin : g_lane
            assign w_fill[k*PatternWidth +: PatternWidth] = r_pattern;
            assign w_ramp[k*PatternWidth +: PatternWidth] = r_base + r_step * PatternWidth'(k);
        end
    endgenerate

    // Select the next output beat according to the latched mode
    always_comb begin
        w_beat = w_fill;
        case (r_mode)
            c_mode_ramp:   w_beat = w_ramp;
            c_mode_bypass: w_beat = ext_data_i_bits;
            default:       w_beat = w_fill;
        endcase
    end

    // Job control, beat counters and registered output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_bits     <= '0;
            r_in_left  <= 32'd0;
            r_out_left <= 32'd0;
            r_pattern  <= '0;
            r_step     <= '0;
            r_base     <= '0;
            r_mode     <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ext_start_i && (ext_csr_i_1 != 32'd0)) begin
                        r_pattern  <= ext_csr_i_0[PatternWidth-1:0];
                        r_base     <= ext_csr_i_0[PatternWidth-1:0];
                        r_step     <= w_step;
                        r_mode     <= ext_csr_i_2[1:0];
                        r_in_left  <= ext_csr_i_1;
                        r_out_left <= ext_csr_i_1;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_in_hs) begin
                        r_bits    <= w_beat;
                        r_valid   <= 1'b1;
                        r_in_left <= r_in_left - 32'd1;
                        r_base    <= r_base + w_base_inc;
                    end else if (w_out_hs) begin
                        r_valid <= 1'b0;
                    end
                    if (w_out_hs) begin
                        r_out_left <= r_out_left - 32'd1;
                        if (r_out_left == 32'd1) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ext_data_i_ready = w_in_ready;
    assign ext_data_o_valid = r_valid;
    assign ext_data_o_bits  = r_bits;
    assign ext_busy_o       = r_busy;

endmodule
`default_nettype wire
